// File: rtl/mvu_job_sched_pkg.sv
// Shared types for the MVU job scheduler: job configuration record and FSM states.
`ifndef PITO_NUM_HARTS
`define PITO_NUM_HARTS 8
`endif

package pito_pkg;

   localparam int PITO_NUM_HARTS = `PITO_NUM_HARTS;

   typedef logic [11:0]     mvu_addr_t;
   typedef logic [3:0][7:0] mvu_dim_t;

   // One complete MVU job as written by a hart into its CSRs.
   typedef struct packed {
      mvu_addr_t  wbaseaddr;
      mvu_addr_t  ibaseaddr;
      mvu_addr_t  obaseaddr;
      mvu_dim_t   wstride;
      mvu_dim_t   istride;
      mvu_dim_t   ostride;
      mvu_dim_t   wlength;
      mvu_dim_t   ilength;
      mvu_dim_t   olength;
      logic [5:0] precision;
      logic [3:0] command;
      logic [5:0] quant;
   } mvu_cfg_t;

   localparam int MVU_CFG_W = $bits(mvu_cfg_t);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_RUN    = 2'd2,
      ST_DONE   = 2'd3
   } mvu_sched_state_e;

endpackage

// File: rtl/mvu_job_sched_if.sv
// Start/config/done handshake between the job scheduler and the shared MVU.
interface mvu_job_sched_if;
   import pito_pkg::*;

   logic     mvu_start_o;
   mvu_cfg_t mvu_cfg_o;
   logic     mvu_done_i;

   modport master (output mvu_start_o, output mvu_cfg_o, input mvu_done_i);
   modport slave  (input mvu_start_o, input mvu_cfg_o, output mvu_done_i);
endinterface

// File: rtl/mvu_job_sched_rr_arb.sv
// Combinational round-robin picker: first requester after the last grant, wrapping.
module pito_rr_arb #(
   parameter int N  = 8,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          valid
);

   int            cand;
   logic [IW-1:0] cand_idx;

   always_comb begin
      gnt      = '0;
      gnt_idx  = '0;
      valid    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int i = 1; i <= N; i++) begin
         cand     = (int'(last) + i) % N;
         cand_idx = IW'(cand);
         if (!valid && req[cand_idx]) begin
            valid         = 1'b1;
            gnt_idx       = cand_idx;
            gnt[cand_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mvu_job_sched.sv
// Shares one MVU among NUM_HARTS harts: queues one job per hart, grants round-robin,
// launches it and watches for completion or watchdog expiry.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no job in flight; grant next pending hart if any
// ST_LAUNCH | one-cycle mvu_start_o, watchdog cleared
// ST_RUN    | waiting for mvu_done_i or watchdog terminal count
// ST_DONE   | one-cycle irq to owner, timeout_o if the job was aborted
module mvu_job_sched
   import pito_pkg::*;
#(
   parameter int NUM_HARTS   = PITO_NUM_HARTS,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic                           clk,
   input  logic                           pito_io_rst_n,
   input  logic [NUM_HARTS-1:0]           hart_start_i,
   input  logic [NUM_HARTS*MVU_CFG_W-1:0] hart_cfg_i,
   output logic [NUM_HARTS-1:0]           hart_irq_o,
   output logic [NUM_HARTS-1:0]           hart_pend_o,
   mvu_job_sched_if.master                mvu,
   output logic [$clog2(NUM_HARTS)-1:0]   owner_o,
   output logic                           active_o,
   output logic                           timeout_o
);

   localparam int IW = $clog2(NUM_HARTS);
   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   mvu_sched_state_e     state_q, state_d;
   logic [NUM_HARTS-1:0] pend_q, pend_d, pend_clr;
   logic [IW-1:0]        owner_q, owner_d, last_q, last_d;
   mvu_cfg_t             cfg_q, cfg_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 abort_q, abort_d;

   logic [NUM_HARTS-1:0] gnt_oh;
   logic [IW-1:0]        gnt_idx;
   logic                 gnt_valid;

   pito_rr_arb #(.N(NUM_HARTS), .IW(IW)) u_arb (
      .req     (pend_q),
      .last    (last_q),
      .gnt     (gnt_oh),
      .gnt_idx (gnt_idx),
      .valid   (gnt_valid)
   );

   always_comb begin
      state_d         = state_q;
      pend_clr        = '0;
      owner_d         = owner_q;
      last_d          = last_q;
      cfg_d           = cfg_q;
      cnt_d           = cnt_q;
      abort_d         = abort_q;
      mvu.mvu_start_o = 1'b0;
      hart_irq_o      = '0;
      timeout_o       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (gnt_valid) begin
               pend_clr = gnt_oh;
               owner_d  = gnt_idx;
               last_d   = gnt_idx;
               cfg_d    = hart_cfg_i[gnt_idx*MVU_CFG_W +: MVU_CFG_W];
               state_d  = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            mvu.mvu_start_o = 1'b1;
            cnt_d           = '0;
            abort_d         = 1'b0;
            state_d         = ST_RUN;
         end
         ST_RUN: begin
            if (mvu.mvu_done_i) begin
               state_d = ST_DONE;
            end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
               abort_d = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            hart_irq_o[owner_q] = 1'b1;
            timeout_o           = abort_q;
            state_d             = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // A new request in the grant cycle re-arms the bit, so set beats clear.
      pend_d = (pend_q & ~pend_clr) | hart_start_i;
   end

   always_ff @(posedge clk) begin
      if (!pito_io_rst_n) begin
         state_q <= ST_IDLE;
         pend_q  <= '0;
         owner_q <= '0;
         last_q  <= IW'(NUM_HARTS - 1);
         cfg_q   <= '0;
         cnt_q   <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cfg_q   <= cfg_d;
         cnt_q   <= cnt_d;
         abort_q <= abort_d;
      end
   end

   assign hart_pend_o   = pend_q;
   assign owner_o       = owner_q;
   assign mvu.mvu_cfg_o = cfg_q;
   assign active_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mvu_job_sched.sv
// Randomized and directed checks of mvu_job_sched against a job-level reference model.
module tb_mvu_job_sched;
   import pito_pkg::*;

   localparam int N  = 8;
   localparam int TO = 16;
   localparam int W  = MVU_CFG_W;

   logic           clk = 1'b0;
   logic           rst_b;
   logic [N-1:0]   hart_start;
   logic [N*W-1:0] hart_cfg;
   logic [N-1:0]   hart_irq, hart_pend;
   logic [2:0]     owner;
   logic           active, tmo;

   mvu_job_sched_if mvu_bus ();

   mvu_job_sched #(.NUM_HARTS(N), .TIMEOUT_CYC(TO)) dut (
      .clk           (clk),
      .pito_io_rst_n (rst_b),
      .hart_start_i  (hart_start),
      .hart_cfg_i    (hart_cfg),
      .hart_irq_o    (hart_irq),
      .hart_pend_o   (hart_pend),
      .mvu           (mvu_bus),
      .owner_o       (owner),
      .active_o      (active),
      .timeout_o     (tmo)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int last_launch = -100;

   // Job-level reference: pending set, current job (owner, cycles since launch), completion flag.
   logic [N-1:0] m_pend;
   int           m_owner, m_last, m_age;
   logic         m_busy, m_fin, m_abort;
   mvu_cfg_t     m_cfg;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic mvu_cfg_t rand_cfg();
      logic [255:0] t;
      for (int k = 0; k < 8; k++) t[k*32 +: 32] = $urandom;
      return t[W-1:0];
   endfunction

   task automatic model_step(input logic [N-1:0] st, input logic dn, input logic rb);
      logic [N-1:0] clr;
      clr = '0;
      if (!rb) begin
         m_pend = '0; m_owner = 0; m_last = N - 1; m_cfg = '0;
         m_busy = 1'b0; m_fin = 1'b0; m_abort = 1'b0; m_age = 0;
         return;
      end
      if (m_fin) begin
         m_fin = 1'b0;
      end else if (m_busy) begin
         if (m_age == 0) m_age = 1;
         else if (dn) begin m_busy = 1'b0; m_fin = 1'b1; m_abort = 1'b0; end
         else if (m_age == TO) begin m_busy = 1'b0; m_fin = 1'b1; m_abort = 1'b1; end
         else m_age++;
      end else if (m_pend != '0) begin
         for (int k = 1; k <= N; k++) begin
            int h;
            h = (m_last + k) % N;
            if (m_pend[h]) begin
               clr[h] = 1'b1; m_owner = h; m_last = h;
               m_cfg = hart_cfg[h*W +: W];
               m_busy = 1'b1; m_age = 0;
               break;
            end
         end
      end
      m_pend = (m_pend & ~clr) | st;
   endtask

   task automatic compare_model();
      logic [N-1:0] e_irq;
      e_irq = m_fin ? (N'(1) << m_owner) : '0;
      chk("start",   mvu_bus.mvu_start_o, m_busy && m_age == 0);
      chk("irq",     hart_irq, e_irq);
      chk("timeout", tmo, m_fin && m_abort);
      chk("active",  active, m_busy || m_fin);
      chk("pend",    hart_pend, m_pend);
      chk("owner",   owner, m_owner);
      chk("cfg",     mvu_bus.mvu_cfg_o, m_cfg);
      if (mvu_bus.mvu_start_o === 1'b1) begin
         if (last_launch >= 0) chk("start_gap_ge4", (cyc - last_launch) >= 4, 1'b1);
         last_launch = cyc;
      end
   endtask

   task automatic tick(input logic [N-1:0] st, input logic dn, input logic rb);
      hart_start         = st;
      mvu_bus.mvu_done_i = dn;
      rst_b              = rb;
      model_step(st, dn, rb);
      @(negedge clk);
      cyc++;
      if (!rb) last_launch = -100;
      compare_model();
   endtask

   task automatic wait_launch(input string name);
      int n = 0;
      while (mvu_bus.mvu_start_o !== 1'b1 && n < 30) begin
         tick('0, 1'b0, 1'b1);
         n++;
      end
      chk(name, mvu_bus.mvu_start_o, 1'b1);
   endtask

   // Runs the job currently being launched; mid starts are applied in the launch cycle.
   task automatic run_job(input int exp_owner, input int run_len, input logic [N-1:0] mid);
      wait_launch("launch_seen");
      chk("grant_owner", owner, exp_owner);
      tick(mid, 1'b0, 1'b1);
      for (int i = 1; i < run_len; i++) tick('0, 1'b0, 1'b1);
      tick('0, 1'b1, 1'b1);
      chk("owner_irq", hart_irq, N'(1) << exp_owner);
      chk("owner_irq_no_tmo", tmo, 1'b0);
      tick('0, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      for (int i = 0; i < 3; i++) tick('0, 1'b0, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
      $fatal(1, "simulation time limit");
   end

   initial begin
      mvu_cfg_t cfg2;
      int       c0, n;
      hart_start = '0; mvu_bus.mvu_done_i = 1'b0; rst_b = 1'b0;
      for (int h = 0; h < N; h++) hart_cfg[h*W +: W] = rand_cfg();

      // reset values
      do_reset();
      chk("rst_active", active, 1'b0);
      chk("rst_pend", hart_pend, 8'h00);
      chk("rst_owner", owner, 3'd0);
      chk("rst_cfg", mvu_bus.mvu_cfg_o, '0);
      tick('0, 1'b0, 1'b1);

      // single job on hart 2, start-to-launch latency 2, done-to-irq latency 1
      cfg2 = rand_cfg();
      hart_cfg[2*W +: W] = cfg2;
      tick(8'h04, 1'b0, 1'b1);
      chk("single_t1_start", mvu_bus.mvu_start_o, 1'b0);
      chk("single_t1_pend", hart_pend, 8'h04);
      tick('0, 1'b0, 1'b1);
      chk("single_t2_start", mvu_bus.mvu_start_o, 1'b1);
      chk("single_owner", owner, 3'd2);
      chk("single_cfg", mvu_bus.mvu_cfg_o, cfg2);
      hart_cfg[2*W +: W] = rand_cfg();
      for (int i = 0; i < 7; i++) tick('0, 1'b0, 1'b1);
      chk("single_cfg_held", mvu_bus.mvu_cfg_o, cfg2);
      tick('0, 1'b1, 1'b1);
      chk("single_irq", hart_irq, 8'h04);
      tick('0, 1'b0, 1'b1);
      chk("single_idle", active, 1'b0);

      // contention 0,3,7 then wrap fairness {1,6} after owner 7
      do_reset();
      tick(8'h89, 1'b0, 1'b1);
      run_job(0, 3, '0);
      run_job(3, 2, '0);
      run_job(7, 1, 8'h42);
      run_job(1, 2, '0);
      run_job(6, 4, '0);

      // watchdog abort on hart 5
      tick(8'h20, 1'b0, 1'b1);
      wait_launch("to_launch");
      c0 = cyc; n = 0;
      while (hart_irq === '0 && n < 40) begin tick('0, 1'b0, 1'b1); n++; end
      chk("to_latency", cyc - c0, 17);
      chk("to_irq", hart_irq, 8'h20);
      chk("to_pulse", tmo, 1'b1);
      tick('0, 1'b0, 1'b1);
      chk("to_back_idle", active, 1'b0);

      // reset during RUN drops the job
      tick(8'h02, 1'b0, 1'b1);
      wait_launch("rr_launch");
      tick('0, 1'b0, 1'b1);
      tick(8'h08, 1'b0, 1'b1);
      tick('0, 1'b0, 1'b0);
      chk("rr_pend", hart_pend, 8'h00);
      chk("rr_active", active, 1'b0);
      tick('0, 1'b1, 1'b1);
      chk("rr_no_irq", hart_irq, 8'h00);
      chk("rr_idle", active, 1'b0);

      // requeue: hart 4 restarts in its grant cycle and during its own RUN
      tick(8'h10, 1'b0, 1'b1);
      tick(8'h10, 1'b0, 1'b1);
      chk("rq_launch", mvu_bus.mvu_start_o, 1'b1);
      chk("rq_pend_setwins", hart_pend, 8'h10);
      tick('0, 1'b0, 1'b1);
      tick(8'h10, 1'b0, 1'b1);
      tick('0, 1'b1, 1'b1);
      chk("rq_irq1", hart_irq, 8'h10);
      run_job(4, 2, '0);
      chk("rq_drained", hart_pend, 8'h00);
      tick('0, 1'b1, 1'b1);
      chk("stray_done_irq", hart_irq, 8'h00);
      chk("stray_done_active", active, 1'b0);
      tick('0, 1'b0, 1'b1);
      chk("stray_no_start", mvu_bus.mvu_start_o, 1'b0);

      // randomized traffic
      for (int e = 0; e < 6; e++) begin
         int pdone;
         pdone = (e % 2 == 0) ? 30 : 3;
         for (int i = 0; i < 500; i++) begin
            logic [N-1:0] st;
            logic         dn, rb;
            if ($urandom_range(3) == 0) hart_cfg[$urandom_range(N-1)*W +: W] = rand_cfg();
            for (int h = 0; h < N; h++) st[h] = ($urandom_range(15) == 0);
            dn = ($urandom_range(99) < (active ? pdone : 5));
            rb = ($urandom_range(399) != 0);
            tick(st, dn, rb);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
